code_lock_ctrl: RTL and testbench

CODE_LOCK_CTRL -- requirements
Module: code_lock_ctrl

---
 rtl/code_lock_pkg.sv | 25 ++
 rtl/code_lock_if.sv | 27 ++
 rtl/lockout_timer.sv | 36 +++
 rtl/code_lock_ctrl.sv | 153 +++++++++++++++
 tb/tb_code_lock_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/code_lock_pkg.sv
// Shared key codes, controller state encoding and sizing helpers for the keypad code lock.
package code_lock_pkg;

   localparam int unsigned KEY_W  = 5;
   localparam int unsigned FAIL_W = 4;

   localparam logic [KEY_W-1:0] KEY_CLEAR = 5'b11100;
   localparam logic [KEY_W-1:0] KEY_ENTER = 5'b11110;
   localparam logic [KEY_W-1:0] KEY_PROG  = 5'b11101;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ENTRY,
      ST_GOOD,
      ST_BAD,
      ST_LOCKOUT,
      ST_PROG_ENTRY
   } lockStateT;

   // Bits needed to hold a digit count of 0..codeLen inclusive.
   function automatic int unsigned cntWidth(input int unsigned codeLen);
      return $clog2(codeLen + 1);
   endfunction

endpackage

// File: rtl/code_lock_if.sv
// Keypad-side bus of the code lock: key strobes in, status pulses and LEDs out.
interface code_lock_if
   import code_lock_pkg::*;
#(
   parameter int unsigned CODE_LEN = 4
) ();

   logic                new_key;
   logic [KEY_W-1:0]    key_code;
   logic                override;
   logic                unlock_pulse;
   logic                fail_pulse;
   logic                lockout;
   logic                prog_mode;
   logic [CODE_LEN-1:0] pin_leds;

   modport master (
      output new_key, key_code, override,
      input  unlock_pulse, fail_pulse, lockout, prog_mode, pin_leds
   );

   modport slave (
      input  new_key, key_code, override,
      output unlock_pulse, fail_pulse, lockout, prog_mode, pin_leds
   );

endinterface

// File: rtl/lockout_timer.sv
// Lockout duration counter: started for one cycle, raises done in the last busy cycle.
module lockout_timer #(
   parameter int unsigned LOCKOUT_CYC = 1000
) (
   input  logic clk5,
   input  logic reset,
   input  logic start,
   output logic busy,
   output logic done
);

   localparam int unsigned TMR_W = $clog2(LOCKOUT_CYC);

   logic [TMR_W-1:0] tmr;

   // done is registered one count early so it lines up with the final lockout cycle.
   always_ff @(posedge clk5) begin
      if (reset) begin
         tmr  <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else if (start) begin
         tmr  <= '0;
         busy <= 1'b1;
         done <= 1'b0;
      end else if (done) begin
         tmr  <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else if (busy) begin
         tmr  <= tmr + TMR_W'(1);
         done <= (tmr == TMR_W'(LOCKOUT_CYC - 2));
      end
   end

endmodule

// File: rtl/code_lock_ctrl.sv
// Keypad code lock: digit entry with match tracking, consecutive-fail lockout,
// and re-programming of the unlock code after a successful entry.
module code_lock_ctrl
   import code_lock_pkg::*;
#(
   parameter int unsigned CODE_LEN    = 4,
   parameter int unsigned MAX_FAIL    = 3,
   parameter int unsigned LOCKOUT_CYC = 1000,
   parameter logic [CODE_LEN*KEY_W-1:0] DEFAULT_CODE = 20'hA4E51
) (
   input logic        clk5,
   input logic        reset,
   code_lock_if.slave kp
);

   localparam int unsigned CNT_W = cntWidth(CODE_LEN);
   localparam int unsigned IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;

   lockStateT                      state, stateNxt;
   logic [CNT_W-1:0]               count, countNxt;
   logic                           match, matchNxt;
   logic                           armed, armedNxt;
   logic [FAIL_W-1:0]              failCnt, failCntNxt, failInc;
   logic [CODE_LEN-1:0][KEY_W-1:0] codeReg, codeNxt, shadow, shadowNxt;
   logic [IDX_W-1:0]               idx;
   logic                           keyOk, isClear, isEnter, isProg, full;
   logic                           timerStart, timerBusy, timerDone;
   logic                           lockoutSt;
   logic [CODE_LEN-1:0]            leds;

   lockout_timer #(.LOCKOUT_CYC(LOCKOUT_CYC)) uTimer (
      .clk5  (clk5),
      .reset (reset),
      .start (timerStart),
      .busy  (timerBusy),
      .done  (timerDone)
   );

   assign keyOk   = kp.new_key & ~kp.override & ~lockoutSt;
   assign isClear = (kp.key_code == KEY_CLEAR);
   assign isEnter = (kp.key_code == KEY_ENTER);
   assign isProg  = (kp.key_code == KEY_PROG);
   assign full    = (count == CNT_W'(CODE_LEN));
   assign idx     = IDX_W'(count);
   assign failInc = failCnt + FAIL_W'(1);

   always_ff @(posedge clk5) begin
      if (reset) begin
         state   <= ST_IDLE;
         count   <= '0;
         match   <= 1'b1;
         failCnt <= '0;
         armed   <= 1'b0;
         codeReg <= DEFAULT_CODE;
         shadow  <= '0;
      end else begin
         state   <= stateNxt;
         count   <= countNxt;
         match   <= matchNxt;
         failCnt <= failCntNxt;
         armed   <= armedNxt;
         codeReg <= codeNxt;
         shadow  <= shadowNxt;
      end
   end

   always_comb begin
      stateNxt   = state;
      countNxt   = count;
      matchNxt   = match;
      failCntNxt = failCnt;
      armedNxt   = armed;
      codeNxt    = codeReg;
      shadowNxt  = shadow;
      timerStart = 1'b0;
      unique case (state)
         ST_IDLE, ST_ENTRY: begin
            if (keyOk) begin
               // Leaving the freshly-unlocked idle state with anything but PROG disarms programming.
               if (state == ST_IDLE && !isProg) armedNxt = 1'b0;
               if (isClear) begin
                  countNxt = '0;
                  matchNxt = 1'b1;
                  stateNxt = ST_IDLE;
               end else if (isEnter) begin
                  if (full && match)      stateNxt = ST_GOOD;
                  else if (count != '0)   stateNxt = ST_BAD;
               end else if (isProg) begin
                  if (state == ST_IDLE && armed && count == '0) stateNxt = ST_PROG_ENTRY;
               end else if (!full) begin
                  countNxt = count + CNT_W'(1);
                  if (kp.key_code != codeReg[idx]) matchNxt = 1'b0;
                  stateNxt = ST_ENTRY;
               end
            end
         end
         ST_GOOD: begin
            failCntNxt = '0;
            armedNxt   = 1'b1;
            countNxt   = '0;
            matchNxt   = 1'b1;
            stateNxt   = ST_IDLE;
         end
         ST_BAD: begin
            failCntNxt = failInc;
            armedNxt   = 1'b0;
            countNxt   = '0;
            matchNxt   = 1'b1;
            if (failInc == FAIL_W'(MAX_FAIL)) begin
               timerStart = 1'b1;
               stateNxt   = ST_LOCKOUT;
            end else begin
               stateNxt = ST_IDLE;
            end
         end
         ST_LOCKOUT: begin
            if (timerDone || !timerBusy) begin
               failCntNxt = '0;
               stateNxt   = ST_IDLE;
            end
         end
         ST_PROG_ENTRY: begin
            if (keyOk) begin
               if (isClear || (isEnter && !full)) begin
                  armedNxt = 1'b0;
                  countNxt = '0;
                  stateNxt = ST_IDLE;
               end else if (isEnter) begin
                  codeNxt  = shadow;
                  countNxt = '0;
                  stateNxt = ST_IDLE;
               end else if (!isProg && !full) begin
                  shadowNxt[idx] = kp.key_code;
                  countNxt       = count + CNT_W'(1);
               end
            end
         end
         default: stateNxt = ST_IDLE;
      endcase
   end

   always_comb begin
      lockoutSt = (state == ST_LOCKOUT);
      leds      = '0;
      for (int i = 0; i < CODE_LEN; i++) leds[i] = (count > CNT_W'(i));
      kp.unlock_pulse = (state == ST_GOOD);
      kp.fail_pulse   = (state == ST_BAD);
      kp.lockout      = lockoutSt;
      kp.prog_mode    = (state == ST_PROG_ENTRY);
      kp.pin_leds     = leds;
   end

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Bench for code_lock_ctrl: directed key sequences checked every cycle against a queue-based model.
module tb_code_lock_ctrl;

   localparam int unsigned N    = 4;
   localparam int unsigned MAXF = 3;
   localparam int unsigned LCYC = 1000;

   localparam logic [4:0] K1 = 5'b10001, K2 = 5'b10010, K3 = 5'b10011, K4 = 5'b10100;
   localparam logic [4:0] K5 = 5'b10101, K6 = 5'b10110, K7 = 5'b10111, K8 = 5'b11000;
   localparam logic [4:0] K9 = 5'b11001;
   localparam logic [4:0] KC = 5'b11100, KE = 5'b11110, KP = 5'b11101;

   logic clk5 = 1'b0;
   logic reset = 1'b1;
   bit   checkEn = 1'b0;
   int   nCompared = 0;
   int   nMismatch = 0;
   int   cyc = 0;

   code_lock_if #(.CODE_LEN(N)) kp ();

   code_lock_ctrl #(
      .CODE_LEN(N), .MAX_FAIL(MAXF), .LOCKOUT_CYC(LCYC), .DEFAULT_CODE(20'hA4E51)
   ) dut (
      .clk5(clk5), .reset(reset), .kp(kp)
   );

   always #5 clk5 = ~clk5;

   task automatic checkBit(input string name, input logic got, input logic exp);
      nCompared++;
      if (got !== exp) begin
         nMismatch++;
         $display("FAIL %s cyc %0d: got %b expected %b", name, cyc, got, exp);
      end
   endtask

   task automatic checkLeds(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatch++;
         $display("FAIL %s cyc %0d: got %b expected %b", name, cyc, got, exp);
      end
   endtask

   task automatic checkInt(input string name, input int got, input int exp);
      nCompared++;
      if (got != exp) begin
         nMismatch++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Model: entered digits as a queue, match decided at ENTER, lockout as remaining cycles.
   logic [4:0] mCode [N];
   logic [4:0] q [$];
   int         mFails, mLock, mPulse;
   bit         mArmed, mProg;

   function automatic bit codeMatches();
      for (int i = 0; i < N; i++) if (q[i] != mCode[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [N-1:0] thermo(input int n);
      logic [N-1:0] r;
      r = '0;
      for (int i = 0; i < n; i++) r[i] = 1'b1;
      return r;
   endfunction

   task automatic modelStep();
      logic [4:0] k;
      k = kp.key_code;
      if (reset) begin
         mCode = '{K1, K2, K3, K4};
         q.delete();
         mFails = 0; mLock = 0; mPulse = 0; mArmed = 0; mProg = 0;
      end else if (mPulse != 0) begin
         if (mPulse == 1) begin
            mFails = 0; mArmed = 1;
         end else begin
            mArmed = 0; mFails++;
            if (mFails == MAXF) mLock = LCYC;
         end
         q.delete();
         mPulse = 0;
      end else if (mLock > 0) begin
         mLock--;
         if (mLock == 0) mFails = 0;
      end else if (kp.new_key && !kp.override) begin
         if (mProg) begin
            if (k == KC || (k == KE && q.size() < N)) begin
               mProg = 0; mArmed = 0; q.delete();
            end else if (k == KE) begin
               for (int i = 0; i < N; i++) mCode[i] = q[i];
               mProg = 0; q.delete();
            end else if (k != KP && q.size() < N) begin
               q.push_back(k);
            end
         end else begin
            if (q.size() == 0 && k != KP) mArmed = 0;
            if (k == KC) q.delete();
            else if (k == KE) begin
               if (q.size() > 0) mPulse = (q.size() == N && codeMatches()) ? 1 : 2;
            end else if (k == KP) begin
               if (q.size() == 0 && mArmed) mProg = 1;
            end else if (q.size() < N) q.push_back(k);
         end
      end
   endtask

   initial forever begin
      @(posedge clk5);
      cyc++;
      modelStep();
   end

   always @(negedge clk5) begin
      if (checkEn) begin
         checkBit("m_unlock_pulse", kp.unlock_pulse, mPulse == 1);
         checkBit("m_fail_pulse", kp.fail_pulse, mPulse == 2);
         checkBit("m_lockout", kp.lockout, mLock > 0);
         checkBit("m_prog_mode", kp.prog_mode, mProg);
         checkLeds("m_pin_leds", kp.pin_leds, thermo(q.size()));
      end
   end

   task automatic press(input logic [4:0] k);
      @(negedge clk5);
      kp.new_key = 1'b1; kp.key_code = k;
      @(negedge clk5);
      kp.new_key = 1'b0;
   endtask

   task automatic enterCode(input logic [4:0] a, b, c, d);
      press(a); press(b); press(c); press(d); press(KE);
   endtask

   // Called in the cycle after ENTER: exactly one pulse cycle, then back to an empty entry.
   task automatic expectPulse(input string name, input logic eu, input logic ef);
      checkBit({name, "_unlock"}, kp.unlock_pulse, eu);
      checkBit({name, "_fail"}, kp.fail_pulse, ef);
      @(negedge clk5);
      checkBit({name, "_end"}, kp.unlock_pulse | kp.fail_pulse, 1'b0);
      checkLeds({name, "_leds"}, kp.pin_leds, 4'b0000);
   endtask

   task automatic pulseReset();
      @(negedge clk5); reset = 1'b1;
      @(negedge clk5); reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int lockCyc;
      kp.new_key = 1'b0; kp.key_code = '0; kp.override = 1'b0;
      repeat (3) @(negedge clk5);
      checkEn = 1'b1;
      checkLeds("rst_leds", kp.pin_leds, 4'b0000);
      checkBit("rst_unlock", kp.unlock_pulse, 1'b0);
      checkBit("rst_fail", kp.fail_pulse, 1'b0);
      checkBit("rst_lockout", kp.lockout, 1'b0);
      checkBit("rst_prog", kp.prog_mode, 1'b0);
      reset = 1'b0;

      // Default code unlocks, LED thermometer follows the digit count.
      press(K1); checkLeds("leds_1", kp.pin_leds, 4'b0001);
      press(K2); checkLeds("leds_2", kp.pin_leds, 4'b0011);
      press(K3); checkLeds("leds_3", kp.pin_leds, 4'b0111);
      press(K4); checkLeds("leds_4", kp.pin_leds, 4'b1111);
      press(K9); checkLeds("leds_extra", kp.pin_leds, 4'b1111);
      press(KE); expectPulse("unlock_dflt", 1'b1, 1'b0);

      // Short code fails; CLEAR restarts; success clears the fail count.
      press(K1); press(K2); press(KE); expectPulse("short", 1'b0, 1'b1);
      press(K1); press(K2); press(KC); checkLeds("clear_leds", kp.pin_leds, 4'b0000);
      enterCode(K1, K2, K3, K4); expectPulse("unlock_after_clear", 1'b1, 1'b0);
      enterCode(K1, K2, K9, K4); expectPulse("bad_a", 1'b0, 1'b1);
      enterCode(K1, K2, K9, K4); expectPulse("bad_b", 1'b0, 1'b1);
      checkBit("no_lock_after_two", kp.lockout, 1'b0);
      press(KE); checkBit("enter_empty_ignored", kp.fail_pulse, 1'b0);
      enterCode(K1, K2, K3, K4); expectPulse("unlock_reset_fails", 1'b1, 1'b0);

      // Three consecutive failures lock the keypad for LCYC cycles.
      for (int a = 0; a < 3; a++) begin
         enterCode(K1, K2, K9, K4);
         checkBit("bad_lk_fail", kp.fail_pulse, 1'b1);
         @(negedge clk5);
      end
      checkBit("lockout_on", kp.lockout, 1'b1);
      lockCyc = 1;
      for (int i = 0; i < 1100; i++) begin
         @(negedge clk5);
         if (!kp.lockout) break;
         lockCyc++;
         kp.new_key  = (i % 100 == 5);
         kp.key_code = K1;
         kp.override = (i >= 200 && i < 400);
      end
      kp.new_key = 1'b0; kp.override = 1'b0;
      checkInt("lockout_len", lockCyc, 1000);
      checkLeds("leds_after_lock", kp.pin_leds, 4'b0000);
      enterCode(K1, K2, K3, K4); expectPulse("unlock_after_lock", 1'b1, 1'b0);

      // Programming a new code after unlock.
      press(KP); checkBit("prog_on", kp.prog_mode, 1'b1);
      press(K5); press(K6); press(K7); press(K8);
      checkBit("prog_still", kp.prog_mode, 1'b1);
      checkLeds("prog_leds", kp.pin_leds, 4'b1111);
      press(KE); checkBit("prog_off", kp.prog_mode, 1'b0);
      enterCode(K1, K2, K3, K4); expectPulse("old_code_fails", 1'b0, 1'b1);
      enterCode(K5, K6, K7, K8); expectPulse("new_code_unlocks", 1'b1, 1'b0);

      // Reset restores the default code; PROG is ignored unless armed; abort keeps the code.
      pulseReset();
      press(KP); checkBit("prog_unarmed", kp.prog_mode, 1'b0);
      checkLeds("prog_not_digit", kp.pin_leds, 4'b0000);
      enterCode(K1, K2, K3, K4); expectPulse("dflt_after_rst", 1'b1, 1'b0);
      press(KP); checkBit("prog_on2", kp.prog_mode, 1'b1);
      press(K5); press(K6); press(KC);
      checkBit("prog_abort", kp.prog_mode, 1'b0);
      press(KP); checkBit("prog_disarmed", kp.prog_mode, 1'b0);
      enterCode(K1, K2, K3, K4); expectPulse("code_kept", 1'b1, 1'b0);

      // Override freezes entry, which then resumes.
      press(K1); press(K2);
      kp.override = 1'b1; press(K9);
      checkLeds("ovr_frozen", kp.pin_leds, 4'b0011);
      kp.override = 1'b0;
      press(K3); press(K4); press(KE); expectPulse("ovr_resume", 1'b1, 1'b0);

      // Reset mid-entry with a key blocked by override, then a key coincident with reset.
      press(K1); press(K2);
      kp.override = 1'b1; press(K3);
      checkLeds("ovr_k3", kp.pin_leds, 4'b0011);
      kp.override = 1'b0;
      pulseReset();
      checkLeds("rst_mid_entry", kp.pin_leds, 4'b0000);
      press(K1);
      @(negedge clk5);
      reset = 1'b1; kp.new_key = 1'b1; kp.key_code = K2;
      @(negedge clk5);
      reset = 1'b0; kp.new_key = 1'b0;
      checkLeds("rst_wins_key", kp.pin_leds, 4'b0000);
      enterCode(K1, K2, K3, K4); expectPulse("unlock_final", 1'b1, 1'b0);

      repeat (2) @(negedge clk5);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
